// File: rtl/counter_timer_pkg.sv
// Shared register map and CONFIG/STATUS field positions for the counter/timer block.
package counter_timer_pkg;

   // Byte offsets of the four registers inside one 16-byte channel window.
   localparam logic [3:0] OFS_CONFIG = 4'h0;
   localparam logic [3:0] OFS_VALUE  = 4'h4;
   localparam logic [3:0] OFS_DATA   = 4'h8;
   localparam logic [3:0] OFS_STATUS = 4'hC;

   typedef enum logic [1:0] {
      REG_CONFIG = 2'd0,
      REG_VALUE  = 2'd1,
      REG_DATA   = 2'd2,
      REG_STATUS = 2'd3
   } reg_sel_e;

   // CONFIG field positions; everything above CFG_W-1 reads as zero.
   localparam int CFG_W       = 5;
   localparam int CFG_EN      = 0;
   localparam int CFG_ONESHOT = 1;
   localparam int CFG_UP      = 2;
   localparam int CFG_IRQ_EN  = 3;
   localparam int CFG_CHAIN   = 4;

   // Sticky terminal-count flag in STATUS.
   localparam int STATUS_TC = 0;

   // Byte-lane merge of a bus write into an existing 32-bit register image.
   function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                                input logic [31:0] wdat,
                                                input logic [3:0]  sel);
      logic [31:0] res;
      res = cur;
      for (int b = 0; b < 4; b++) begin
         if (sel[b]) res[8*b +: 8] = wdat[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/counter_timer_multi_if.sv
// Wishbone classic slave bus bundle for the multi-channel counter/timer.
interface counter_timer_multi_if;
   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic        wb_we_i;
   logic [3:0]  wb_sel_i;
   logic [31:0] wb_adr_i;
   logic [31:0] wb_dat_i;
   logic        wb_ack_o;
   logic [31:0] wb_dat_o;

   modport master (
      output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
      input  wb_ack_o, wb_dat_o
   );

   modport slave (
      input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
      output wb_ack_o, wb_dat_o
   );
endinterface

// File: rtl/counter_timer_chan.sv
// One counter channel: CONFIG/VALUE/DATA/STATUS registers, step logic and terminal detect.
// tc is combinational from registers so a chained successor steps in the same cycle.
module counter_timer_chan
   import counter_timer_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  reg_sel_e         wr_reg,
   input  logic [3:0]       wr_sel,
   input  logic [31:0]      wr_dat,
   input  logic             chain_in,
   output logic [CFG_W-1:0] cfg,
   output logic [WIDTH-1:0] value,
   output logic [WIDTH-1:0] data,
   output logic             status,
   output logic             tc,
   output logic             irq
);

   logic advance;
   logic at_end;
   logic term;
   logic wr_cfg, wr_value, wr_data, wr_status;

   assign advance   = cfg[CFG_EN] & (~cfg[CFG_CHAIN] | chain_in);
   assign at_end    = cfg[CFG_UP] ? (value == data) : (value == '0);
   assign term      = advance & at_end;
   assign tc        = term;
   assign irq       = status & cfg[CFG_IRQ_EN];

   assign wr_cfg    = wr_en & (wr_reg == REG_CONFIG);
   assign wr_value  = wr_en & (wr_reg == REG_VALUE);
   assign wr_data   = wr_en & (wr_reg == REG_DATA);
   assign wr_status = wr_en & (wr_reg == REG_STATUS);

   // CONFIG: bus write beats the oneshot self-disable on a terminal event.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cfg <= '0;
      end else if (wr_cfg) begin
         cfg <= CFG_W'(merge_bytes(32'(cfg), wr_dat, wr_sel));
      end else if (term && cfg[CFG_ONESHOT]) begin
         cfg[CFG_EN] <= 1'b0;
      end
   end

   // VALUE: bus write beats any step or reload; oneshot terminal simply holds.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value <= '0;
      end else if (wr_value) begin
         value <= WIDTH'(merge_bytes(32'(value), wr_dat, wr_sel));
      end else if (term) begin
         if (!cfg[CFG_ONESHOT]) value <= cfg[CFG_UP] ? '0 : data;
      end else if (advance) begin
         value <= cfg[CFG_UP] ? value + WIDTH'(1) : value - WIDTH'(1);
      end
   end

   // DATA: reload / compare operand, bus-writable only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data <= '0;
      end else if (wr_data) begin
         data <= WIDTH'(merge_bytes(32'(data), wr_dat, wr_sel));
      end
   end

   // STATUS: sticky terminal flag, write-one-to-clear, a coincident terminal keeps it set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         status <= 1'b0;
      end else if (term) begin
         status <= 1'b1;
      end else if (wr_status && wr_sel[0] && wr_dat[STATUS_TC]) begin
         status <= 1'b0;
      end
   end

endmodule

// File: rtl/counter_timer_multi.sv
// Multi-channel counter/timer: Wishbone decode, zero-wait-state ack and registered read mux.
module counter_timer_multi
   import counter_timer_pkg::*;
#(
   parameter int          NCH      = 2,
   parameter int          WIDTH    = 32,
   parameter logic [31:0] BASE_ADR = 32'h2000_0000
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_i,
   counter_timer_multi_if.slave  wb,
   output logic [NCH-1:0]        irq,
   output logic [NCH-1:0]        tc
);

   logic             req;
   logic [31:0]      off;
   logic             in_range;
   logic             reg_ok;
   logic             hit;
   logic [2:0]       chan_idx;
   reg_sel_e         reg_sel;
   logic [31:0]      rd_mux;

   logic [CFG_W-1:0] ch_cfg    [NCH];
   logic [WIDTH-1:0] ch_value  [NCH];
   logic [WIDTH-1:0] ch_data   [NCH];
   logic             ch_status [NCH];

   // A transfer is taken in the first request cycle that is not already being acked.
   assign req      = wb.wb_cyc_i & wb.wb_stb_i & ~wb.wb_ack_o;
   assign off      = wb.wb_adr_i - BASE_ADR;
   assign in_range = off[31:4] < 28'(NCH);
   assign chan_idx = off[6:4];
   assign hit      = in_range & reg_ok;

   // Register select within a channel window; misaligned offsets are unmapped.
   always_comb begin
      reg_ok  = 1'b1;
      reg_sel = REG_CONFIG;
      case (off[3:0])
         OFS_CONFIG: reg_sel = REG_CONFIG;
         OFS_VALUE:  reg_sel = REG_VALUE;
         OFS_DATA:   reg_sel = REG_DATA;
         OFS_STATUS: reg_sel = REG_STATUS;
         default:    reg_ok  = 1'b0;
      endcase
   end

   for (genvar n = 0; n < NCH; n++) begin : g_ch
      logic chain_in;
      logic tc_n;
      logic irq_n;

      if (n == 0) begin : g_first
         assign chain_in = 1'b1;
      end else begin : g_next
         assign chain_in = g_ch[n-1].tc_n;
      end

      counter_timer_chan #(.WIDTH(WIDTH)) u_chan (
         .clk      (wb_clk_i),
         .rst      (wb_rst_i),
         .wr_en    (req & wb.wb_we_i & hit & (chan_idx == 3'(n))),
         .wr_reg   (reg_sel),
         .wr_sel   (wb.wb_sel_i),
         .wr_dat   (wb.wb_dat_i),
         .chain_in (chain_in),
         .cfg      (ch_cfg[n]),
         .value    (ch_value[n]),
         .data     (ch_data[n]),
         .status   (ch_status[n]),
         .tc       (tc_n),
         .irq      (irq_n)
      );

      assign tc[n]  = tc_n;
      assign irq[n] = irq_n;
   end

   // Read mux over the addressed channel register; unmapped space returns zero.
   always_comb begin
      rd_mux = '0;
      if (hit) begin
         for (int i = 0; i < NCH; i++) begin
            if (chan_idx == 3'(i)) begin
               case (reg_sel)
                  REG_CONFIG: rd_mux = 32'(ch_cfg[i]);
                  REG_VALUE:  rd_mux = 32'(ch_value[i]);
                  REG_DATA:   rd_mux = 32'(ch_data[i]);
                  REG_STATUS: rd_mux[STATUS_TC] = ch_status[i];
                  default:    rd_mux = '0;
               endcase
            end
         end
      end
   end

   // Single-cycle ack with read data captured on the accepting edge.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         wb.wb_ack_o <= 1'b0;
         wb.wb_dat_o <= '0;
      end else begin
         wb.wb_ack_o <= req;
         wb.wb_dat_o <= (req && !wb.wb_we_i) ? rd_mux : '0;
      end
   end

endmodule

// File: tb/tb_counter_timer_multi.sv
// Self-checking bench for counter_timer_multi (NCH=2, WIDTH=32).
module tb_counter_timer_multi;

   localparam int          NCH  = 2;
   localparam logic [31:0] BASE = 32'h2000_0000;
   localparam int          O_CFG = 0, O_VAL = 4, O_DAT = 8, O_STA = 12;

   logic           clk;
   logic           rst;
   logic [NCH-1:0] irq;
   logic [NCH-1:0] tc;

   counter_timer_multi_if bus();

   counter_timer_multi #(.NCH(NCH), .WIDTH(32), .BASE_ADR(BASE)) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .wb       (bus),
      .irq      (irq),
      .tc       (tc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks   = 0;
   int failures = 0;

   // scoreboard of expected read data, pushed when a read is driven
   logic [31:0] exp_q[$];

   // monitor-owned state
   int          cyc_cnt = 0;
   int          tc_cnt  [NCH] = '{default: 0};
   int          tc_last [NCH] = '{default: 0};
   int          tc_intv [NCH] = '{default: 0};
   int          rd_seen = 0;
   logic [31:0] rd_cap  = '0;

   always @(negedge clk) begin
      cyc_cnt = cyc_cnt + 1;
      for (int i = 0; i < NCH; i++) begin
         if (tc[i]) begin
            tc_intv[i] = cyc_cnt - tc_last[i];
            tc_last[i] = cyc_cnt;
            tc_cnt[i]  = tc_cnt[i] + 1;
         end
      end
      if (bus.wb_ack_o && !bus.wb_we_i) begin
         rd_cap  = bus.wb_dat_o;
         rd_seen = rd_seen + 1;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [31:0] ra(input int ch, input int ofs);
      return BASE + 32'(ch * 16 + ofs);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
      end
   endtask

   task automatic bus_drive(input logic we, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] s);
      bus.wb_cyc_i = 1'b1;
      bus.wb_stb_i = 1'b1;
      bus.wb_we_i  = we;
      bus.wb_adr_i = a;
      bus.wb_dat_i = d;
      bus.wb_sel_i = s;
   endtask

   task automatic bus_ack_phase();
      @(posedge clk); #1;
      chk("ack_high", 32'(bus.wb_ack_o), 32'd1);
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
   endtask

   task automatic bus_idle();
      @(posedge clk); #1;
      chk("ack_low", 32'(bus.wb_ack_o), 32'd0);
      bus.wb_we_i = 1'b0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
      bus_drive(1'b1, a, d, s);
      bus_ack_phase();
      bus_idle();
   endtask

   task automatic rd_start(input logic [31:0] a, input logic [31:0] exp);
      exp_q.push_back(exp);
      bus_drive(1'b0, a, 32'h0, 4'h0);
   endtask

   task automatic rd_finish(input string nm, input int seen0);
      logic [31:0] e;
      bus_ack_phase();
      bus_idle();
      chk({nm, "_seen"}, 32'(rd_seen), 32'(seen0 + 1));
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      chk(nm, rd_cap, e);
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
      int s0;
      s0 = rd_seen;
      rd_start(a, exp);
      rd_finish(nm, s0);
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   typedef struct {
      logic [31:0] cfg;
      logic [31:0] data;
      logic [31:0] val0;
      int          d;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [12];

   initial begin
      int base0, base1, s0;

      // {config, data, start value, idle cycles, expected frozen value}
      vecs[0]  = '{32'h1, 32'h5, 32'h5,         0, 32'h3};
      vecs[1]  = '{32'h1, 32'h5, 32'h5,         1, 32'h2};
      vecs[2]  = '{32'h1, 32'h5, 32'h5,         3, 32'h0};
      vecs[3]  = '{32'h1, 32'h5, 32'h5,         4, 32'h5};
      vecs[4]  = '{32'h1, 32'h5, 32'h5,         5, 32'h4};
      vecs[5]  = '{32'h5, 32'h3, 32'h0,         1, 32'h3};
      vecs[6]  = '{32'h5, 32'h3, 32'h0,         2, 32'h0};
      vecs[7]  = '{32'h5, 32'h1, 32'hFFFF_FFFE, 0, 32'h0};
      vecs[8]  = '{32'h5, 32'h1, 32'hFFFF_FFFE, 1, 32'h1};
      vecs[9]  = '{32'h3, 32'h9, 32'h2,         5, 32'h0};
      vecs[10] = '{32'h7, 32'h4, 32'h1,         6, 32'h4};
      vecs[11] = '{32'h0, 32'h5, 32'h7,         3, 32'h7};

      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
      bus.wb_we_i  = 1'b0;
      bus.wb_sel_i = 4'h0;
      bus.wb_adr_i = '0;
      bus.wb_dat_i = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ack", 32'(bus.wb_ack_o), 32'd0);
      chk("rst_dat", bus.wb_dat_o, 32'd0);
      chk("rst_irq", 32'(irq), 32'd0);
      chk("rst_tc", 32'(tc), 32'd0);
      rst = 1'b0;

      for (int c = 0; c < NCH; c++) begin
         rd(ra(c, O_CFG), 32'h0, $sformatf("rst_cfg%0d", c));
         rd(ra(c, O_VAL), 32'h0, $sformatf("rst_val%0d", c));
         rd(ra(c, O_DAT), 32'h0, $sformatf("rst_dat%0d", c));
         rd(ra(c, O_STA), 32'h0, $sformatf("rst_sta%0d", c));
      end

      // table: run for 2+d steps from the enabling write, then freeze and read back
      for (int i = 0; i < 12; i++) begin
         wr(ra(0, O_CFG), 32'h0);
         wr(ra(0, O_DAT), vecs[i].data);
         wr(ra(0, O_VAL), vecs[i].val0);
         wr(ra(0, O_CFG), vecs[i].cfg);
         repeat (vecs[i].d) @(posedge clk);
         #1;
         wr(ra(0, O_CFG), 32'h0);
         rd(ra(0, O_VAL), vecs[i].exp, $sformatf("vec%0d_value", i));
      end

      // continuous down DATA=VALUE=5: tc every 6 cycles
      reset_dut();
      wr(ra(0, O_DAT), 32'h5);
      wr(ra(0, O_VAL), 32'h5);
      wr(ra(0, O_CFG), 32'h1);
      base0 = tc_cnt[0];
      base1 = tc_cnt[1];
      repeat (22) @(posedge clk);
      #1;
      chk("down_tc_count", 32'(tc_cnt[0] - base0), 32'd3);
      chk("down_tc_period", 32'(tc_intv[0]), 32'd6);
      chk("down_tc_ch1_quiet", 32'(tc_cnt[1] - base1), 32'd0);

      // up oneshot to 0x19: stops, self-disables, single tc
      reset_dut();
      wr(ra(0, O_DAT), 32'h19);
      wr(ra(0, O_VAL), 32'h0);
      wr(ra(0, O_CFG), 32'h7);
      base0 = tc_cnt[0];
      repeat (40) @(posedge clk);
      #1;
      rd(ra(0, O_VAL), 32'h19, "oneshot_value");
      rd(ra(0, O_CFG), 32'h6, "oneshot_cfg");
      rd(ra(0, O_STA), 32'h1, "oneshot_status");
      chk("oneshot_tc_count", 32'(tc_cnt[0] - base0), 32'd1);
      chk("oneshot_irq_off", 32'(irq), 32'd0);

      // chain: ch1 steps only on ch0 terminal cycles
      reset_dut();
      wr(ra(0, O_DAT), 32'h3);
      wr(ra(0, O_VAL), 32'h3);
      wr(ra(1, O_DAT), 32'h2);
      wr(ra(1, O_VAL), 32'h2);
      wr(ra(1, O_CFG), 32'h11);
      wr(ra(0, O_CFG), 32'h1);
      repeat (9) @(posedge clk);
      #1;
      rd(ra(1, O_STA), 32'h0, "chain_status_before");
      rd(ra(1, O_STA), 32'h1, "chain_status_after");
      rd(ra(1, O_VAL), 32'h2, "chain_reload");
      rd(ra(1, O_VAL), 32'h1, "chain_step");

      // irq and write-one-to-clear, DATA=0 gives tc every cycle
      reset_dut();
      wr(ra(0, O_CFG), 32'h9);
      chk("irq_set", 32'(irq[0]), 32'd1);
      base0 = tc_cnt[0];
      repeat (10) @(posedge clk);
      #1;
      chk("tc_every_cycle", 32'(tc_cnt[0] - base0), 32'd10);
      wr(ra(0, O_STA), 32'h1);
      chk("irq_set_wins", 32'(irq[0]), 32'd1);
      wr(ra(0, O_CFG), 32'h8);
      chk("irq_held", 32'(irq[0]), 32'd1);
      bus_drive(1'b1, ra(0, O_STA), 32'h1, 4'hF);
      bus_ack_phase();
      chk("irq_clear_next", 32'(irq[0]), 32'd0);
      bus_idle();
      rd(ra(0, O_STA), 32'h0, "status_cleared");
      wr(ra(0, O_CFG), 32'h1);
      rd(ra(0, O_STA), 32'h1, "status_no_irq_en");
      chk("irq_masked", 32'(irq[0]), 32'd0);

      // byte lanes, field masking, unmapped space
      reset_dut();
      wr(ra(0, O_DAT), 32'hdcba_7cfb, 4'b0001);
      rd(ra(0, O_DAT), 32'h0000_00fb, "sel_byte0");
      wr(ra(0, O_DAT), 32'h1122_3344, 4'b1010);
      rd(ra(0, O_DAT), 32'h1100_33fb, "sel_bytes13");
      wr(ra(1, O_CFG), 32'hFFFF_FFF2);
      rd(ra(1, O_CFG), 32'h0000_0012, "cfg_mask");
      wr(ra(4, O_VAL), 32'h5555_5555);
      rd(ra(4, O_VAL), 32'h0, "unmapped_ch4");
      rd(BASE + 32'h40, 32'h0, "unmapped_0x40");
      rd(BASE - 32'h4, 32'h0, "below_base");
      rd(ra(1, O_VAL), 32'h0, "unmapped_write_ignored");

      // reset in the middle of a pending read while counting
      reset_dut();
      wr(ra(0, O_DAT), 32'hFFFF);
      wr(ra(0, O_VAL), 32'h12bc);
      wr(ra(0, O_CFG), 32'h9);
      rd(ra(0, O_VAL), 32'h12bb, "pre_reset_value");
      s0 = rd_seen;
      rd_start(ra(0, O_VAL), 32'h0);
      #3;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_ack", 32'(bus.wb_ack_o), 32'd0);
      chk("abort_dat", bus.wb_dat_o, 32'd0);
      chk("abort_tc", 32'(tc), 32'd0);
      chk("abort_irq", 32'(irq), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_ack2", 32'(bus.wb_ack_o), 32'd0);
      rd_finish("post_reset_value", s0);
      rd(ra(0, O_CFG), 32'h0, "post_reset_cfg");
      rd(ra(0, O_DAT), 32'h0, "post_reset_data");
      rd(ra(0, O_STA), 32'h0, "post_reset_status");

      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
